// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller: FSM encoding and
// default sizing of the in-flight write tracking.
package hazard_ctrl_pkg;

  localparam int PEND_DEPTH_DEF = 2;
  localparam int REG_W_DEF      = 3;
  localparam int CNT_W_DEF      = 16;

  // 2'b11 is unused and recovers to ST_RUN.
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } ctrl_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight register writes (ID/EX, EX/MEM) and the RAW
// compare of the decode sources against every tracked destination.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int PEND_DEPTH = PEND_DEPTH_DEF,
  parameter int REG_W      = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_v,
  input  logic [REG_W-1:0] load_wr,
  input  logic [REG_W-1:0] rs,
  input  logic             rs_used,
  input  logic [REG_W-1:0] rt,
  input  logic             rt_used,
  output logic             raw_hit
);

  logic [PEND_DEPTH-1:0] ent_v;
  logic [REG_W-1:0]      ent_wr [PEND_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_v <= '0;
      for (int i = 0; i < PEND_DEPTH; i++) ent_wr[i] <= '0;
    end else begin
      ent_v[0]  <= load_v;
      ent_wr[0] <= load_wr;
      for (int i = 1; i < PEND_DEPTH; i++) begin
        ent_v[i]  <= ent_v[i-1];
        ent_wr[i] <= ent_wr[i-1];
      end
    end
  end

  // r0 is an ordinary register here, so no special-casing of specifier 0.
  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < PEND_DEPTH; i++) begin
      if (ent_v[i] && ((rs_used && (rs == ent_wr[i])) ||
                       (rt_used && (rt == ent_wr[i]))))
        raw_hit = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage sequencing controller: RAW stall, branch squash and HALT drain,
// plus a saturating count of RAW-stall cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int PEND_DEPTH = PEND_DEPTH_DEF,
  parameter int REG_W      = REG_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic             id_regWrite,
  input  logic [REG_W-1:0] id_write_reg,
  input  logic             id_halt,
  input  logic             ex_branch_taken,
  output logic             stall_pc,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             halt_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int                DCNT_W    = $clog2(PEND_DEPTH + 2);
  localparam logic [DCNT_W-1:0] DRAIN_LEN = DCNT_W'(PEND_DEPTH + 1);

  ctrl_state_t       state, state_nxt;
  logic [DCNT_W-1:0] drain_cnt, drain_cnt_nxt;
  logic [CNT_W-1:0]  stall_cnt_nxt;
  logic              raw_hit;
  logic              sb_load_v;

  hazard_scoreboard #(
    .PEND_DEPTH (PEND_DEPTH),
    .REG_W      (REG_W)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .load_v  (sb_load_v),
    .load_wr (id_write_reg),
    .rs      (id_rs),
    .rs_used (id_rs_used),
    .rt      (id_rt),
    .rt_used (id_rt_used),
    .raw_hit (raw_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    stall_cnt_nxt = stall_cnt;
    stall_pc      = 1'b0;
    flush_if_id   = 1'b0;
    bubble_id_ex  = 1'b0;
    halt_done     = 1'b0;

    case (state)
      ST_RUN: begin
        // A taken branch squashes whatever sits in decode, stall or HALT alike.
        if (ex_branch_taken) begin
          flush_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
        end else if (id_valid && raw_hit) begin
          stall_pc     = 1'b1;
          bubble_id_ex = 1'b1;
          if (stall_cnt != '1) stall_cnt_nxt = stall_cnt + CNT_W'(1);
        end else if (id_valid && id_halt) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = DRAIN_LEN;
        end
      end
      ST_DRAIN: begin
        stall_pc      = 1'b1;
        flush_if_id   = 1'b1;
        bubble_id_ex  = 1'b1;
        drain_cnt_nxt = drain_cnt - DCNT_W'(1);
        if (drain_cnt <= DCNT_W'(1)) state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        stall_pc     = 1'b1;
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
        halt_done    = 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase

    // Keep the pipe controls quiet while reset is held, before state settles.
    if (rst) begin
      stall_pc     = 1'b0;
      flush_if_id  = 1'b0;
      bubble_id_ex = 1'b0;
      halt_done    = 1'b0;
    end

    sb_load_v = id_valid & id_regWrite & ~stall_pc & ~bubble_id_ex;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl; expected responses come from a
// cycle-level behavioural model and are checked by a queue-driven monitor.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs_used, id_rt_used, id_regWrite, id_halt, ex_branch_taken;
  logic [2:0]  id_rs, id_rt, id_write_reg;
  logic        stall_pc, flush_if_id, bubble_id_ex, halt_done;
  logic [15:0] stall_cnt;
  logic        s_stall, s_flush, s_bubble, s_halt;
  logic [2:0]  s_cnt;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_regWrite(id_regWrite),
    .id_write_reg(id_write_reg), .id_halt(id_halt), .ex_branch_taken(ex_branch_taken),
    .stall_pc(stall_pc), .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
    .halt_done(halt_done), .stall_cnt(stall_cnt)
  );

  // Narrow counter copy so saturation is reached quickly.
  hazard_ctrl #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_regWrite(id_regWrite),
    .id_write_reg(id_write_reg), .id_halt(id_halt), .ex_branch_taken(ex_branch_taken),
    .stall_pc(s_stall), .flush_if_id(s_flush), .bubble_id_ex(s_bubble),
    .halt_done(s_halt), .stall_cnt(s_cnt)
  );

  typedef struct packed {
    logic       valid;
    logic [2:0] rs;
    logic       rs_used;
    logic [2:0] rt;
    logic       rt_used;
    logic       regw;
    logic [2:0] wreg;
    logic       halt;
    logic       br;
  } in_t;

  typedef struct {
    logic        stall, flush, bubble, hd;
    logic [15:0] cnt;
    logic [2:0]  cnt_s;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: pipeline mode, remaining drain cycles, recent issued writes.
  int mode = 0;          // 0 running, 1 draining, 2 halted
  int drain_left = 0;
  int hist_v[2] = '{0, 0};
  int hist_r[2] = '{0, 0};
  int cnt16 = 0;
  int cnt3  = 0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".stall_pc"},     int'(stall_pc),     int'(e.stall));
      chk({e.tag, ".flush_if_id"},  int'(flush_if_id),  int'(e.flush));
      chk({e.tag, ".bubble_id_ex"}, int'(bubble_id_ex), int'(e.bubble));
      chk({e.tag, ".halt_done"},    int'(halt_done),    int'(e.hd));
      chk({e.tag, ".stall_cnt"},    int'(stall_cnt),    int'(e.cnt));
      chk({e.tag, ".stall_cnt_sat"}, int'(s_cnt),       int'(e.cnt_s));
    end
  end

  task automatic cycle(input logic r, input in_t s, input bit do_chk, input string tag);
    exp_t e;
    bit   hit, stalled, issue;
    rst = r;
    id_valid = s.valid; id_rs = s.rs; id_rs_used = s.rs_used; id_rt = s.rt;
    id_rt_used = s.rt_used; id_regWrite = s.regw; id_write_reg = s.wreg;
    id_halt = s.halt; ex_branch_taken = s.br;

    hit = 0;
    for (int k = 0; k < 2; k++)
      if (hist_v[k] != 0 && ((s.rs_used && int'(s.rs) == hist_r[k]) ||
                             (s.rt_used && int'(s.rt) == hist_r[k])))
        hit = 1;
    e.stall = 0; e.flush = 0; e.bubble = 0; e.hd = 0;
    e.cnt = 16'(cnt16); e.cnt_s = 3'(cnt3); e.tag = tag;
    stalled = 0;
    if (!r) begin
      if (mode == 0) begin
        if (s.br) begin e.flush = 1; e.bubble = 1; end
        else if (s.valid && hit) begin e.stall = 1; e.bubble = 1; stalled = 1; end
      end else begin
        e.stall = 1; e.flush = 1; e.bubble = 1; e.hd = (mode == 2);
      end
    end
    issue = !r && s.valid && s.regw && !e.stall && !e.bubble;
    if (do_chk) exp_q.push_back(e);

    @(posedge clk);
    if (r) begin
      mode = 0; drain_left = 0; cnt16 = 0; cnt3 = 0;
      hist_v = '{0, 0}; hist_r = '{0, 0};
    end else begin
      if (stalled) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt3 < 7) cnt3++;
      end
      if (mode == 0 && !s.br && !stalled && s.valid && s.halt) begin
        mode = 1; drain_left = 3;
      end else if (mode == 1) begin
        drain_left--;
        if (drain_left == 0) mode = 2;
      end
      hist_v[1] = hist_v[0]; hist_r[1] = hist_r[0];
      hist_v[0] = issue;     hist_r[0] = int'(s.wreg);
    end
    #1;
  endtask

  function automatic in_t nop();
    in_t s = '0;
    s.valid = 1; s.rs = 3'd6; s.rt = 3'd7;
    return s;
  endfunction

  function automatic in_t prod(input logic [2:0] d);
    in_t s = nop();
    s.regw = 1; s.wreg = d;
    return s;
  endfunction

  function automatic in_t rnd_in();
    in_t s;
    s = in_t'($urandom);
    s.rs = 3'($urandom_range(0, 3)); s.rt = 3'($urandom_range(0, 3));
    s.wreg = 3'($urandom_range(0, 3));
    s.halt = ($urandom_range(0, 63) == 0);
    s.br = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  initial begin
    in_t s;
    rst = 1'b1;
    id_valid = 0; id_rs = 0; id_rs_used = 0; id_rt = 0; id_rt_used = 0;
    id_regWrite = 0; id_write_reg = 0; id_halt = 0; ex_branch_taken = 0;
    @(posedge clk); #1;

    // reset with random inputs; first cycle counters not yet settled
    cycle(1, rnd_in(), 0, "rst0");
    cycle(1, rnd_in(), 1, "rst1");
    s = nop(); s.rs_used = 1; s.rt_used = 1; s.rs = 3'd0; s.rt = 3'd0;
    cycle(0, s, 1, "empty_sb");

    // back-to-back RAW on rs: two stall cycles
    cycle(0, prod(3'd3), 1, "raw_rs.prod");
    s = nop(); s.rs = 3'd3; s.rs_used = 1;
    for (int i = 0; i < 3; i++) cycle(0, s, 1, "raw_rs.cons");

    // one unrelated instruction between: one stall on rt
    cycle(0, prod(3'd3), 1, "raw_rt.prod");
    cycle(0, prod(3'd5), 1, "raw_rt.mid");
    s = nop(); s.rt = 3'd3; s.rt_used = 1;
    for (int i = 0; i < 2; i++) cycle(0, s, 1, "raw_rt.cons");

    // unused source and non-writing producer never stall
    cycle(0, prod(3'd3), 1, "unused.prod");
    s = nop(); s.rs = 3'd3;
    cycle(0, s, 1, "unused.cons");
    s = nop(); s.wreg = 3'd2;
    cycle(0, s, 1, "nowr.prod");
    s = nop(); s.rs = 3'd2; s.rs_used = 1;
    cycle(0, s, 1, "nowr.cons");

    // branch beats a simultaneous RAW stall and HALT
    cycle(0, prod(3'd4), 1, "br.prod");
    s = prod(3'd1); s.rs = 3'd4; s.rs_used = 1; s.halt = 1; s.br = 1;
    cycle(0, s, 1, "br.squash");
    s = nop(); s.rs = 3'd1; s.rs_used = 1;
    cycle(0, s, 1, "br.after");
    cycle(0, nop(), 1, "br.after2");

    // HALT drain then sticky halted
    s = nop(); s.halt = 1;
    cycle(0, s, 1, "halt.dec");
    for (int i = 0; i < 6; i++) begin
      s = rnd_in(); s.br = 1;
      cycle(0, s, 1, "halt.drain");
    end

    // reset during drain aborts it
    cycle(1, nop(), 1, "rst.halted");
    s = nop(); s.halt = 1;
    cycle(0, s, 1, "halt2.dec");
    cycle(0, nop(), 1, "halt2.drain");
    cycle(1, nop(), 1, "halt2.rst");
    for (int i = 0; i < 3; i++) cycle(0, nop(), 1, "halt2.run");

    // randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++)
      cycle(($urandom_range(0, 149) == 0), rnd_in(), 1, "rnd");

    cycle(0, nop(), 0, "tail");
    cycle(0, nop(), 0, "tail");
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
